bias_feeder: RTL and testbench
==============================

# bias_feeder

Transmit side of the per-column bias interface. Collects one 16-bit bias scalar per systolic-array column over a valid/ready stream, then broadcasts the full vector in one cycle with a load pulse into the bias units' inactive registers. On request it issues a single-cycle switch pulse, so the next layer's biases become active at a layer boundary. Sits between the unified buffer / host bias stream and the row of bias units below the systolic array.

## Interface
- COLS, 2, number of array columns (bias units driven); ≥1
- DATA_W, 16, bias scalar width (signed fixed point, passed through untouched)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- start_in  in  1  pulse: begin collecting a new bias vector
- clear_in  in  1  synchronous abort: return to IDLE, column count to 0
- bias_in_valid  in  1  stream beat valid
- bias_in_ready  out  1  feeder accepts a beat this cycle
- bias_in_data  in  DATA_W  signed bias scalar, column order 0..COLS-1
- switch_req_in  in  1  layer boundary: promote loaded biases to active
- load_bias_out  out  1  one-cycle global load strobe to all bias units
- bias_scalar_out  out  COLS*DATA_W  staged vector; column c in bits [c*DATA_W +: DATA_W]
- bias_switch_out  out  1  one-cycle switch pulse to all bias units
- armed_out  out  1  vector loaded, waiting for switch_req_in
- busy_out  out  1  state != IDLE

## Operation
- FSM states: IDLE, COLLECT, LOAD, ARMED, SWITCH.
- IDLE: start_in=1 → COLLECT, col_cnt=0. All other inputs are ignored.
- COLLECT: bias_in_ready=1. On valid&&ready, staging[col_cnt]<=bias_in_data and col_cnt increments. A beat accepted at col_cnt==COLS-1 → LOAD, col_cnt=0.
- LOAD: load_bias_out=1 for exactly one cycle, bias_scalar_out stable, then → ARMED.
- ARMED: armed_out=1. switch_req_in=1 → SWITCH.
- SWITCH: bias_switch_out=1 for exactly one cycle, then → IDLE.
- switch_req_in outside ARMED: ignored, not latched.
- start_in outside IDLE: ignored.
- clear_in: highest priority in every state. Next state is IDLE, col_cnt=0, and no load or switch pulse is issued. Staging contents are retained.
- bias_scalar_out is driven directly from the staging registers. It may change during COLLECT and is valid only while load_bias_out=1. It holds until the next accepted beat.
- No arithmetic. Data is copied bit-exact.
- Reset values: load_bias_out=0, bias_switch_out=0, bias_in_ready=0, armed_out=0, busy_out=0, bias_scalar_out=0, state=IDLE, col_cnt=0.
- Reset asserted mid-operation aborts immediately. No pulse is emitted.

## Timing
- All outputs are decoded from registered state and staging (Moore). There are no combinational input→output paths.
- start_in high in cycle 0 → bias_in_ready high from cycle 1.
- With valid held high: beats are accepted in cycles 1..COLS, load_bias_out is high in cycle COLS+1, and armed_out is high from cycle COLS+2.
- switch_req_in high in cycle k while ARMED → bias_switch_out high in cycle k+1 → IDLE (busy_out=0) in cycle k+2.
- Bubbles (valid=0) stall col_cnt without limit. There is no timeout.

## Configuration
- BIAS_FEEDER_ZERO_EN defined:
  - Adds input zero_load_in (1 bit).
  - zero_load_in in IDLE clears all staging to 0 and goes directly to LOAD. This covers bias-free layers.
  - If zero_load_in and start_in are both high in IDLE, zero_load_in wins.
- Not defined: the port is absent, and the only path to LOAD is through COLLECT.

## Structure
- Package bias_feeder_pkg holds:
  - typedef enum logic [2:0] feeder_state_t {IDLE, COLLECT, LOAD, ARMED, SWITCH}
  - localparam DATA_W_DEFAULT=16
- col_cnt width is $clog2(COLS), minimum 1.
- No sub-module: a single FSM with a staging register array.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0; release → IDLE, bias_in_ready=0.
- COLS=2, start, beats 0x0100 then 0xFF80 back-to-back → load_bias_out high in cycle 3 with bias_scalar_out=0xFF80_0100; armed_out high from cycle 4.
- ARMED, switch_req_in pulse → exactly one bias_switch_out cycle, then busy_out=0. A second switch_req_in in IDLE → no pulse.
- Valid gaps: beats separated by 3 idle cycles → col_cnt stalls, a single load pulse, correct vector.
- clear_in after the first beat → IDLE, no load_bias_out. A fresh start with 0x0001, 0x0002 → vector 0x0002_0001.
- BIAS_FEEDER_ZERO_EN: zero_load_in in IDLE → load_bias_out with bias_scalar_out=0 next cycle, no stream beats consumed.

Source files
------------

// File: rtl/bias_feeder_pkg.sv
// rtl/bias_feeder_pkg.sv - shared types and defaults for the bias feeder
//
// Purpose : FSM state encoding and the default bias scalar width used by
//           bias_feeder and bias_feeder_if.
// Contents: feeder_state_t (IDLE, COLLECT, LOAD, ARMED, SWITCH),
//           DATA_W_DEFAULT.

package bias_feeder_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        LOAD,
        ARMED,
        SWITCH
    } feeder_state_t;

endpackage

// File: rtl/bias_feeder_if.sv
// rtl/bias_feeder_if.sv - valid/ready bias scalar stream into the feeder
//
// Purpose : Groups the incoming bias stream handshake.
// Signals : bias_in_valid  beat valid (source -> feeder)
//           bias_in_ready  feeder accepts the beat (feeder -> source)
//           bias_in_data   signed bias scalar, column order 0..COLS-1
// Modports: master = stream source, slave = bias_feeder.

import bias_feeder_pkg::*;

interface bias_feeder_if #(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic              bias_in_valid;
    logic              bias_in_ready;
    logic [DATA_W-1:0] bias_in_data;

    modport master (
        output bias_in_valid,
        output bias_in_data,
        input  bias_in_ready
    );

    modport slave (
        input  bias_in_valid,
        input  bias_in_data,
        output bias_in_ready
    );
endinterface

// File: rtl/bias_feeder.sv
// rtl/bias_feeder.sv - collects per-column biases and broadcasts load/switch pulses
//
// Purpose : Accepts COLS bias scalars over a valid/ready stream into a staging
//           array, pulses load_bias_out for one cycle with the full vector on
//           bias_scalar_out, then waits (armed) for a layer-boundary request
//           and emits a single-cycle bias_switch_out.
// Ports   : clk, rst (async, active-low)
//           start_in        begin collecting a vector (IDLE only)
//           clear_in        synchronous abort to IDLE, staging kept
//           switch_req_in   promote loaded biases (ARMED only)
//           zero_load_in    load an all-zero vector (BIAS_FEEDER_ZERO_EN only)
//           bias_in         bias_feeder_if.slave stream
//           load_bias_out, bias_scalar_out, bias_switch_out, armed_out, busy_out
// Config  : BIAS_FEEDER_ZERO_EN adds zero_load_in.
// All outputs are decoded from registered state/staging only.

import bias_feeder_pkg::*;

module bias_feeder #(
    parameter int COLS   = 2,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic                   clear_in,
    input  logic                   switch_req_in,
`ifdef BIAS_FEEDER_ZERO_EN
    input  logic                   zero_load_in,
`endif
    bias_feeder_if.slave           bias_in,
    output logic                   load_bias_out,
    output logic [COLS*DATA_W-1:0] bias_scalar_out,
    output logic                   bias_switch_out,
    output logic                   armed_out,
    output logic                   busy_out
);

    localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

    feeder_state_t     state_q, state_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [DATA_W-1:0] staging_q [COLS];
    logic [DATA_W-1:0] staging_d [COLS];

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        staging_d = staging_q;

        // clear_in overrides everything; staging is deliberately left intact
        if (clear_in) begin
            state_d   = IDLE;
            col_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef BIAS_FEEDER_ZERO_EN
                    if (zero_load_in) begin
                        for (int c = 0; c < COLS; c++) begin
                            staging_d[c] = '0;
                        end
                        col_cnt_d = '0;
                        state_d   = LOAD;
                    end else
`endif
                    if (start_in) begin
                        col_cnt_d = '0;
                        state_d   = COLLECT;
                    end
                end
                COLLECT: begin
                    // ready is high for the whole of COLLECT, so valid alone accepts
                    if (bias_in.bias_in_valid) begin
                        for (int c = 0; c < COLS; c++) begin
                            if (col_cnt_q == CNT_W'(c)) begin
                                staging_d[c] = bias_in.bias_in_data;
                            end
                        end
                        if (col_cnt_q == LAST_COL) begin
                            col_cnt_d = '0;
                            state_d   = LOAD;
                        end else begin
                            col_cnt_d = col_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD:    state_d = ARMED;
                ARMED:   if (switch_req_in) state_d = SWITCH;
                SWITCH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            for (int c = 0; c < COLS; c++) begin
                staging_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            staging_q <= staging_d;
        end
    end

    assign bias_in.bias_in_ready = (state_q == COLLECT);
    assign load_bias_out         = (state_q == LOAD);
    assign armed_out             = (state_q == ARMED);
    assign bias_switch_out       = (state_q == SWITCH);
    assign busy_out              = (state_q != IDLE);

    for (genvar g = 0; g < COLS; g++) begin : g_out
        assign bias_scalar_out[g*DATA_W +: DATA_W] = staging_q[g];
    end

endmodule

// File: tb/tb_bias_feeder.sv
// tb/tb_bias_feeder.sv - directed self-checking bench for bias_feeder (COLS=2)

`timescale 1ns/1ps

module tb_bias_feeder;

    localparam int COLS   = 2;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic start_in, clear_in, switch_req_in;
`ifdef BIAS_FEEDER_ZERO_EN
    logic zero_load_in;
`endif
    logic                   load_bias_out;
    logic [COLS*DATA_W-1:0] bias_scalar_out;
    logic                   bias_switch_out;
    logic                   armed_out;
    logic                   busy_out;

    int n_cmp = 0;
    int n_err = 0;

    bias_feeder_if #(.DATA_W(DATA_W)) bif ();

    bias_feeder #(.COLS(COLS), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .clear_in        (clear_in),
        .switch_req_in   (switch_req_in),
`ifdef BIAS_FEEDER_ZERO_EN
        .zero_load_in    (zero_load_in),
`endif
        .bias_in         (bif.slave),
        .load_bias_out   (load_bias_out),
        .bias_scalar_out (bias_scalar_out),
        .bias_switch_out (bias_switch_out),
        .armed_out       (armed_out),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs set afterwards are sampled at the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic rdy, input logic ld,
                             input logic arm, input logic sw, input logic bsy);
        chk({tag, ".ready"},  {63'd0, bif.bias_in_ready}, {63'd0, rdy});
        chk({tag, ".load"},   {63'd0, load_bias_out},     {63'd0, ld});
        chk({tag, ".armed"},  {63'd0, armed_out},         {63'd0, arm});
        chk({tag, ".switch"}, {63'd0, bias_switch_out},   {63'd0, sw});
        chk({tag, ".busy"},   {63'd0, busy_out},          {63'd0, bsy});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start_in = 1'b0; clear_in = 1'b0; switch_req_in = 1'b0;
`ifdef BIAS_FEEDER_ZERO_EN
        zero_load_in = 1'b0;
`endif
        bif.bias_in_valid = 1'b0;
        bif.bias_in_data  = '0;

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            tick();
            start_in          = 1'($urandom);
            clear_in          = 1'($urandom);
            switch_req_in     = 1'($urandom);
            bif.bias_in_valid = 1'($urandom);
            bif.bias_in_data  = 16'($urandom);
        end
        tick();
        chk_flags("rst_hold", 0, 0, 0, 0, 0);
        chk("rst_hold.vec", 64'(bias_scalar_out), 64'h0);

        start_in = 0; clear_in = 0; switch_req_in = 0;
        bif.bias_in_valid = 0; bif.bias_in_data = '0;
        rst = 1'b1;
        tick();
        chk_flags("rst_rel", 0, 0, 0, 0, 0);

        // back-to-back beats: start in cycle 0
        start_in = 1;
        tick();                                   // cycle 1
        start_in = 0;
        chk_flags("c1", 1, 0, 0, 0, 1);
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h0100;
        tick();                                   // cycle 2
        chk_flags("c2", 1, 0, 0, 0, 1);
        bif.bias_in_data = 16'hFF80;
        tick();                                   // cycle 3
        bif.bias_in_valid = 0;
        chk_flags("c3", 0, 1, 0, 0, 1);
        chk("c3.vec", 64'(bias_scalar_out), 64'hFF80_0100);
        tick();                                   // cycle 4
        chk_flags("c4", 0, 0, 1, 0, 1);
        // start outside IDLE is ignored
        start_in = 1;
        tick();
        start_in = 0;
        chk_flags("c5", 0, 0, 1, 0, 1);

        // switch request while armed
        switch_req_in = 1;
        tick();
        switch_req_in = 0;
        chk_flags("sw_k1", 0, 0, 0, 1, 1);
        tick();
        chk_flags("sw_k2", 0, 0, 0, 0, 0);
        // switch request in IDLE is not honoured or remembered
        switch_req_in = 1;
        tick();
        switch_req_in = 0;
        chk_flags("sw_idle1", 0, 0, 0, 0, 0);
        tick();
        chk_flags("sw_idle2", 0, 0, 0, 0, 0);

        // beats separated by idle gaps
        start_in = 1;
        tick();
        start_in = 0;
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h1234;
        tick();
        bif.bias_in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk_flags("gap", 1, 0, 0, 0, 1);
            chk("gap.vec", 64'(bias_scalar_out), 64'hFF80_1234);
            tick();
        end
        bif.bias_in_valid = 1; bif.bias_in_data = 16'hABCD;
        tick();
        bif.bias_in_valid = 0;
        chk_flags("gap_ld", 0, 1, 0, 0, 1);
        chk("gap_ld.vec", 64'(bias_scalar_out), 64'hABCD_1234);
        tick();
        chk_flags("gap_arm", 0, 0, 1, 0, 1);

        // clear while armed: straight to IDLE, no switch
        clear_in = 1; switch_req_in = 1;
        tick();
        clear_in = 0; switch_req_in = 0;
        chk_flags("clr_arm", 0, 0, 0, 0, 0);

        // clear after first beat: no load, staging retained
        start_in = 1;
        tick();
        start_in = 0;
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h5555;
        tick();
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h7777;
        clear_in = 1;
        tick();
        clear_in = 0;
        bif.bias_in_valid = 0;
        chk_flags("clr1", 0, 0, 0, 0, 0);
        chk("clr1.vec", 64'(bias_scalar_out), 64'hABCD_5555);
        tick();
        chk_flags("clr2", 0, 0, 0, 0, 0);

        // fresh vector after clear restarts at column 0
        start_in = 1;
        tick();
        start_in = 0;
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h0001;
        tick();
        bif.bias_in_data = 16'h0002;
        tick();
        bif.bias_in_valid = 0;
        chk_flags("fresh_ld", 0, 1, 0, 0, 1);
        chk("fresh_ld.vec", 64'(bias_scalar_out), 64'h0002_0001);
        tick();
        chk_flags("fresh_arm", 0, 0, 1, 0, 1);

        // asynchronous reset while armed
        #2;
        rst = 1'b0;
        #1;
        chk_flags("arst", 0, 0, 0, 0, 0);
        chk("arst.vec", 64'(bias_scalar_out), 64'h0);
        tick();
        rst = 1'b1;
        tick();
        chk_flags("arst_rel", 0, 0, 0, 0, 0);

`ifdef BIAS_FEEDER_ZERO_EN
        // zero load wins over start, no beats consumed
        start_in = 1;
        tick();
        start_in = 0;
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h4321;
        tick();
        bif.bias_in_data = 16'h8765;
        tick();
        bif.bias_in_valid = 0;
        chk("zl_pre.vec", 64'(bias_scalar_out), 64'h8765_4321);
        tick();
        switch_req_in = 1;
        tick();
        switch_req_in = 0;
        tick();
        zero_load_in = 1; start_in = 1;
        bif.bias_in_valid = 1; bif.bias_in_data = 16'h9999;
        tick();
        zero_load_in = 0; start_in = 0;
        chk_flags("zl_ld", 0, 1, 0, 0, 1);
        chk("zl_ld.vec", 64'(bias_scalar_out), 64'h0);
        tick();
        bif.bias_in_valid = 0;
        chk_flags("zl_arm", 0, 0, 1, 0, 1);
        chk("zl_arm.vec", 64'(bias_scalar_out), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
